mmu_ls_unit: RTL

Load/store execution stage directly downstream of the MMU instruction decoder. Accepts one decoded MMU op (ld/st, register address, memory-location address) per handshake and moves a data word between the register file and the memory-location store. Uses a valid/ready request/response protocol to memory with a response timeout. Reports completion or error to the control path.

---
 rtl/mmu_ls_unit_if.sv | 58 +++++
 rtl/mmu_ls_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mmu_ls_unit_if.sv
// Bundle of the op, register-file, memory and status signals of the load/store unit.
// Latency: none, wires only.
// Backpressure: op_ready and mem_req_ready carry the valid/ready stalls.
interface mmu_ls_unit_if #(
    parameter int DATA_W = 32,
    parameter int LOC_AW = 4
);
    // decoded op channel
    logic              op_valid;
    logic              op_ready;
    logic              op_ld;
    logic              op_st;
    logic [3:0]        op_reg_addr;
    logic [LOC_AW-1:0] op_loc_addr;

    // register file side
    logic [3:0]        rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_wr_en;
    logic [3:0]        rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    // memory-location store side
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [LOC_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    // completion status to the control path
    logic              done;
    logic              err;
    logic              busy;

    // environment side: decoder, register file and memory
    modport master (
        output op_valid, op_ld, op_st, op_reg_addr, op_loc_addr,
        input  op_ready,
        input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        output rf_rd_data,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  done, err, busy
    );

    // load/store unit side
    modport slave (
        input  op_valid, op_ld, op_st, op_reg_addr, op_loc_addr,
        output op_ready,
        output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  rf_rd_data,
        output mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output done, err, busy
    );
endinterface

// File: rtl/mmu_ls_unit.sv
// Load/store stage: moves one word between register file and memory-location store per decoded op.
// Latency: accept to done = 1 (invalid op), 4 + request stall + response wait (load or store).
// Backpressure: op_ready only in IDLE, one op in flight; request held until mem_req_ready, response wait bounded by TIMEOUT.
module mmu_ls_unit #(
    parameter int DATA_W  = 32,
    parameter int LOC_AW  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mmu_ls_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RF_READ,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WRITEBACK,
        S_FINISH
    } state_t;

    // Wait counter value on the last MEM_WAIT cycle that may still accept a response.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state;

    // latched op fields
    logic              lat_ld;
    logic [3:0]        lat_reg;

    // cycles spent in MEM_WAIT without a response
    logic [7:0]        wait_cnt;

    // registered outputs
    logic [3:0]        rf_rd_addr_q;
    logic              rf_wr_en_q;
    logic [3:0]        rf_wr_addr_q;
    logic [DATA_W-1:0] rf_wr_data_q;
    logic              mem_req_valid_q;
    logic              mem_we_q;
    logic [LOC_AW-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              done_q;
    logic              err_q;

    // Op sequencing: every output is a register or a direct decode of the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            lat_ld          <= 1'b0;
            lat_reg         <= '0;
            wait_cnt        <= '0;
            rf_rd_addr_q    <= '0;
            rf_wr_en_q      <= 1'b0;
            rf_wr_addr_q    <= '0;
            rf_wr_data_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            // single-cycle strobes fall unless re-armed below
            rf_wr_en_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        lat_ld  <= bus.op_ld;
                        lat_reg <= bus.op_reg_addr;
                        if (bus.op_ld) begin
                            // load wins when both flags are set
                            mem_addr_q      <= bus.op_loc_addr;
                            mem_we_q        <= 1'b0;
                            mem_req_valid_q <= 1'b1;
                            state           <= S_MEM_REQ;
                        end else if (bus.op_st) begin
                            // store first fetches its source register
                            mem_addr_q   <= bus.op_loc_addr;
                            rf_rd_addr_q <= bus.op_reg_addr;
                            state        <= S_RF_READ;
                        end else begin
                            // neither flag: report the op as bad without touching memory
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= S_FINISH;
                        end
                    end
                end

                S_RF_READ: begin
                    mem_wdata_q     <= bus.rf_rd_data;
                    mem_we_q        <= 1'b1;
                    mem_req_valid_q <= 1'b1;
                    state           <= S_MEM_REQ;
                end

                S_MEM_REQ: begin
                    // request fields stay frozen until memory takes them; no timeout here
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        wait_cnt        <= '0;
                        state           <= S_MEM_WAIT;
                    end
                end

                S_MEM_WAIT: begin
                    // a response on the final allowed cycle still counts
                    if (bus.mem_rsp_valid) begin
                        if (lat_ld) begin
                            rf_wr_data_q <= bus.mem_rdata;
                            rf_wr_addr_q <= lat_reg;
                            rf_wr_en_q   <= 1'b1;
                            state        <= S_WRITEBACK;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_FINISH;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= S_FINISH;
                        end
                    end
                end

                S_WRITEBACK: begin
                    done_q <= 1'b1;
                    state  <= S_FINISH;
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready      = (state == S_IDLE);
    assign bus.busy          = (state != S_IDLE);
    assign bus.rf_rd_addr    = rf_rd_addr_q;
    assign bus.rf_wr_en      = rf_wr_en_q;
    assign bus.rf_wr_addr    = rf_wr_addr_q;
    assign bus.rf_wr_data    = rf_wr_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

endmodule
